seg_decoder: RTL

SEG_DECODER -- requirements
Module: seg_decoder

---
 rtl/seg_pkg.sv | 28 ++
 rtl/seg7_to_hex.sv | 27 ++
 rtl/seg_decoder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - segment bit indices, hex pattern table and FSM state type
// Shared by seg7_to_hex and seg_decoder.
package seg_pkg;

  localparam int unsigned SEG_A  = 7;
  localparam int unsigned SEG_B  = 6;
  localparam int unsigned SEG_C  = 5;
  localparam int unsigned SEG_D  = 4;
  localparam int unsigned SEG_E  = 3;
  localparam int unsigned SEG_F  = 2;
  localparam int unsigned SEG_G  = 1;
  localparam int unsigned SEG_DP = 0;

  localparam logic [7:0] SEG_MASK_AG = 8'hFE;

  // Active-high a..g patterns, entry k is hex digit k; dp bit always 0.
  localparam logic [15:0][7:0] SEG_HEX_TABLE = {
    8'h8E, 8'h9E, 8'h7A, 8'h9C, 8'h3E, 8'hEE, 8'hF6, 8'hFE,
    8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOCKED = 2'd2
  } seg_state_e;

endpackage

// File: rtl/seg7_to_hex.sv
// rtl/seg7_to_hex.sv - combinational decode of one active-low seven-segment digit
// Unmatched a..g patterns (including all segments off) decode to 0 with err set.
module seg7_to_hex
  import seg_pkg::*;
(
  input  logic [7:0] seg,
  output logic [3:0] value,
  output logic       dp,
  output logic       err
);

  logic [7:0] lit;

  always_comb begin
    lit   = ~seg;
    dp    = lit[SEG_DP];
    value = 4'h0;
    err   = 1'b1;
    for (int unsigned i = 0; i < 16; i++) begin
      if ((lit & SEG_MASK_AG) == SEG_HEX_TABLE[i[3:0]]) begin
        value = i[3:0];
        err   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg_decoder.sv
// rtl/seg_decoder.sv - debounced eight-digit seven-segment frame decoder
// Define SEG_DECODER_PERIOD_EN to build the update-period measurement.
module seg_decoder
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_NUM = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  i_seg0,
  input  logic [7:0]  i_seg1,
  input  logic [7:0]  i_seg2,
  input  logic [7:0]  i_seg3,
  input  logic [7:0]  i_seg4,
  input  logic [7:0]  i_seg5,
  input  logic [7:0]  i_seg6,
  input  logic [7:0]  i_seg7,
  output logic [31:0] o_digit,
  output logic [7:0]  o_dp,
  output logic [7:0]  o_err,
  output logic        o_valid,
  output logic        o_update,
  output logic [15:0] o_update_cnt,
  output logic [31:0] o_period
);

  localparam logic [15:0] STABLE_MAX = 16'(STABLE_NUM - 1);

  seg_state_e  state_q, state_d;
  logic [63:0] s_d, s_q;
  logic [15:0] stab_q, stab_d;
  logic        s_change;
  logic        lock;
  logic        update;
  logic        first_lock_q;

  logic [31:0] dec_digit;
  logic [7:0]  dec_dp;
  logic [7:0]  dec_err;

  assign s_d = {i_seg7, i_seg6, i_seg5, i_seg4, i_seg3, i_seg2, i_seg1, i_seg0};

  // The incoming sample is judged against the held one at the capture edge,
  // so the capture edge itself counts as the first of the stable samples.
  assign s_change = (s_d != s_q);

  always_comb begin
    stab_d = stab_q;
    if (s_change) begin
      stab_d = 16'd0;
    end else if (stab_q != STABLE_MAX) begin
      stab_d = stab_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lock    = 1'b0;
    if (s_change) begin
      state_d = ST_SETTLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_SETTLE: begin
          if (stab_d == STABLE_MAX) begin
            state_d = ST_LOCKED;
            lock    = 1'b1;
          end
        end
        ST_LOCKED: state_d = ST_LOCKED;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < 8; k++) begin : g_dec
    seg7_to_hex u_dec (
      .seg   (s_q[8*k +: 8]),
      .value (dec_digit[4*k +: 4]),
      .dp    (dec_dp[k]),
      .err   (dec_err[k])
    );
  end

  assign update = lock &&
                  (!first_lock_q || ({dec_digit, dec_dp, dec_err} != {o_digit, o_dp, o_err}));

  assign o_valid = (state_q == ST_LOCKED);

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q          <= 64'd0;
      stab_q       <= 16'd0;
      o_digit      <= 32'd0;
      o_dp         <= 8'd0;
      o_err        <= 8'd0;
      o_update     <= 1'b0;
      o_update_cnt <= 16'd0;
      first_lock_q <= 1'b0;
    end else begin
      s_q      <= s_d;
      stab_q   <= stab_d;
      o_update <= update;
      if (lock) begin
        o_digit      <= dec_digit;
        o_dp         <= dec_dp;
        o_err        <= dec_err;
        first_lock_q <= 1'b1;
      end
      if (update) begin
        o_update_cnt <= o_update_cnt + 16'd1;
      end
    end
  end

`ifdef SEG_DECODER_PERIOD_EN
  logic [31:0] per_cnt_q;
  logic [31:0] period_q;

  // The first update only starts the measurement; o_period stays 0 until the second.
  always_ff @(posedge clk) begin
    if (rst) begin
      per_cnt_q <= 32'd0;
      period_q  <= 32'd0;
    end else if (update) begin
      per_cnt_q <= 32'd0;
      if (first_lock_q) begin
        period_q <= (per_cnt_q == 32'hFFFF_FFFF) ? 32'hFFFF_FFFF : per_cnt_q + 32'd1;
      end
    end else if (per_cnt_q != 32'hFFFF_FFFF) begin
      per_cnt_q <= per_cnt_q + 32'd1;
    end
  end

  assign o_period = period_q;
`else
  assign o_period = 32'd0;
`endif

endmodule
